// File: rtl/z80_snd_responder.sv
// z80_snd_responder: sound-CPU bus target with the host command latch,
// status port, wait-stated reads and the periodic INT tick.
module z80_snd_responder #(
  parameter logic [15:0] LATCH_ADR = 16'hE000,
  parameter bit          USE_IO    = 1'b0,
  parameter int          WAIT_CYC  = 2,
  parameter logic [15:0] TICK_DIV  = 16'd4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic        cmd_wr,
  input  logic [7:0]  cmd_data,
  output logic        cmd_full,
  input  logic [15:0] adr,
  input  logic        mx,
  input  logic        ix,
  input  logic        rd,
  input  logic        intack,
  input  logic        nmiack,
  input  logic        frame_sync,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        wait_n,
  output logic        intreq,
  output logic        nmireq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [15:0] STA_ADR = LATCH_ADR + 16'd1;
  localparam logic [15:0] TOP     = TICK_DIV - 16'd1;
  localparam logic [3:0]  WLD     =
    (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  logic [1:0]  state;
  logic [3:0]  wcnt;
  logic        rd_sta;
  logic [7:0]  cmd_q;
  logic        overrun;
  logic        nmiack_q;
  logic        intack_q;
  logic [15:0] tick_cnt;

  logic        hit_lat;
  logic        hit_sta;
  logic        sel;
  logic [7:0]  status;
  logic        lat_commit;
  logic        sta_commit;
  logic        nmi_edge;
  logic        int_edge;
  logic        tick;

  // Address decode: IO space compares the low byte only.
  always_comb begin
    hit_lat = 1'b0;
    hit_sta = 1'b0;
    if (USE_IO) begin
      hit_lat = adr[7:0] == LATCH_ADR[7:0];
      hit_sta = adr[7:0] == STA_ADR[7:0];
    end else begin
      hit_lat = adr == LATCH_ADR;
      hit_sta = adr == STA_ADR;
    end
  end

  assign sel = (USE_IO ? ix : mx) & rd
             & (hit_lat | hit_sta);

  assign status = {cmd_full, overrun, intreq, nmireq, 4'h0};

  assign lat_commit = clk_en & (state == S_HOLD)
                    & ~sel & ~rd_sta;
  assign sta_commit = clk_en & (state == S_HOLD)
                    & ~sel & rd_sta;

  assign nmi_edge = clk_en & nmiack & ~nmiack_q;
  assign int_edge = intack & ~intack_q;
  assign tick     = ~frame_sync & (tick_cnt == TOP);

  // Command latch, overrun flag and NMI request; host writes win.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q    <= 8'h00;
      cmd_full <= 1'b0;
      overrun  <= 1'b0;
      nmireq   <= 1'b0;
      nmiack_q <= 1'b0;
    end else begin
      if (clk_en) nmiack_q <= nmiack;
      if (cmd_wr) begin
        cmd_q    <= cmd_data;
        cmd_full <= 1'b1;
        nmireq   <= 1'b1;
      end else begin
        if (lat_commit) cmd_full <= 1'b0;
        if (nmi_edge)   nmireq   <= 1'b0;
      end
      if (cmd_wr & cmd_full & ~lat_commit)
        overrun <= 1'b1;
      else if (sta_commit)
        overrun <= 1'b0;
    end
  end

  // Read access FSM: snapshot, wait states, hold until rd drops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      wcnt     <= 4'd0;
      rd_sta   <= 1'b0;
      data_out <= 8'h00;
      data_oe  <= 1'b0;
      wait_n   <= 1'b1;
    end else if (clk_en) begin
      unique case (state)
        S_IDLE: begin
          if (sel) begin
            data_out <= hit_sta ? status : cmd_q;
            data_oe  <= 1'b1;
            rd_sta   <= hit_sta;
            wcnt     <= WLD;
            if (WAIT_CYC == 0) begin
              state <= S_HOLD;
            end else begin
              state  <= S_WAIT;
              wait_n <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (!sel) begin
            state   <= S_IDLE;
            wait_n  <= 1'b1;
            data_oe <= 1'b0;
          end else if (wcnt == 4'd0) begin
            state  <= S_HOLD;
            wait_n <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        S_HOLD: begin
          if (!sel) begin
            state   <= S_IDLE;
            data_oe <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          wait_n  <= 1'b1;
          data_oe <= 1'b0;
        end
      endcase
    end
  end

  // Periodic tick counter and INT request; a new tick beats an ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= 16'd0;
      intreq   <= 1'b0;
      intack_q <= 1'b0;
    end else if (clk_en) begin
      intack_q <= intack;
      if (frame_sync || tick_cnt == TOP)
        tick_cnt <= 16'd0;
      else
        tick_cnt <= tick_cnt + 16'd1;
      if (tick)
        intreq <= 1'b1;
      else if (int_edge)
        intreq <= 1'b0;
    end
  end

endmodule
